logic_gate_unit: RTL and testbench

Parametrised, registered successor to the primitive two-input AND gate. Applies one of eight bitwise two-operand functions to WIDTH-bit operands. Runs in one of two modes: single-shot (one beat in, one result out) or reduce (folds DEPTH beats of operand A through the selected function). Sits between a valid/ready producer and a valid/ready consumer; results are held until accepted.

---
 rtl/logic_gate_unit.sv | 173 +++++++++++++++++
 tb/tb_logic_gate_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise two-operand function unit. It either
// produces one result per beat (single-shot) or folds DEPTH beats of operand A.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             busy
);

  localparam int            CW          = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_BEAT   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_BEAT    = CW'(1'b1);
  localparam logic          SINGLE_BEAT = (DEPTH == 32'sd1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_ANDN: r = x & ~y;
      OP_PASS: r = x;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic parity_fn(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [CW-1:0]    count_r, count_s;
  logic [2:0]       op_r, op_s;
  logic             mode_r, mode_s;
  logic             valid_r, valid_s;

  logic             accept_s;
  logic [CW-1:0]    count_inc_s;
  logic [WIDTH-1:0] shot_s;
  logic [WIDTH-1:0] fold_s;

  assign in_ready    = !rst && (state_r != S_DONE);
  assign accept_s    = in_valid && in_ready;
  assign count_inc_s = count_r + ONE_BEAT;
  // op/mode from the port apply only to the opening beat; later folds use the latched op
  assign shot_s      = gate_fn(op, in_a, in_b);
  assign fold_s      = gate_fn(op_r, acc_r, in_a);

  assign out_valid   = valid_r;
  assign out_data    = data_r;
  assign out_parity  = parity_fn(data_r);
  assign busy        = (state_r != S_IDLE);

  // Next-state and datapath update for the IDLE/ACCUM/DONE controller.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    data_s  = data_r;
    count_s = count_r;
    op_s    = op_r;
    mode_s  = mode_r;
    valid_s = valid_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          op_s   = op;
          mode_s = mode;
          if (!mode) begin
            data_s  = shot_s;
            valid_s = 1'b1;
            state_s = S_DONE;
          end else begin
            acc_s   = in_a;
            count_s = ONE_BEAT;
            if (SINGLE_BEAT) begin
              data_s  = in_a;
              valid_s = 1'b1;
              state_s = S_DONE;
            end else begin
              state_s = S_ACCUM;
            end
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (accept_s) begin
          acc_s   = fold_s;
          count_s = count_inc_s;
          if (count_inc_s == LAST_BEAT) begin
            data_s  = fold_s;
            valid_s = 1'b1;
            state_s = S_DONE;
          end else begin
            state_s = S_ACCUM;
          end
        end else begin
          state_s = S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          valid_s = 1'b0;
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // Registers; reset drops any partial fold or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      acc_r   <= {WIDTH{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
      op_r    <= 3'd0;
      mode_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      data_r  <= data_s;
      count_r <= count_s;
      op_r    <= op_s;
      mode_r  <= mode_s;
      valid_r <= valid_s;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: a transaction-level model checked
// every cycle, plus directed literal expectations, on WIDTH/DEPTH variants.
module tb_logic_gate_unit;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, mode, out_valid, out_ready, out_parity, busy;
  logic [W-1:0] in_a, in_b, out_data;
  logic [2:0]   op;

  logic         d1_in_valid, d1_in_ready, d1_mode, d1_out_valid, d1_out_ready, d1_out_parity, d1_busy;
  logic [W-1:0] d1_in_a, d1_in_b, d1_out_data;
  logic [2:0]   d1_op;

  logic         w1_in_valid, w1_in_ready, w1_mode, w1_out_valid, w1_out_ready, w1_out_parity, w1_busy;
  logic [0:0]   w1_in_a, w1_in_b, w1_out_data;
  logic [2:0]   w1_op;

  logic_gate_unit #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .busy(busy));

  logic_gate_unit #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_a(d1_in_a), .in_b(d1_in_b), .op(d1_op), .mode(d1_mode),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .out_parity(d1_out_parity), .busy(d1_busy));

  logic_gate_unit #(.WIDTH(1), .DEPTH(D)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_b(w1_in_b), .op(w1_op), .mode(w1_mode),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_data(w1_out_data),
    .out_parity(w1_out_parity), .busy(w1_busy));

  int checks = 0;
  int failures = 0;

  // Transaction model: beats collected in a queue, folded once complete.
  logic [7:0] q[$];
  logic [2:0] m_op = 3'd0;
  logic       m_mode = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_zero = 1'b0;
  logic [7:0] exp_data = 8'h00;

  function automatic logic [7:0] fn(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [7:0] r;
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_zero  = 1'b1;
      exp_data  = 8'h00;
    end else if (exp_valid) begin
      if (out_ready) exp_valid = 1'b0;
    end else if (in_valid) begin
      if (q.size() == 0) begin
        m_op   = op;
        m_mode = mode;
      end
      if (!m_mode) begin
        exp_data  = fn(m_op, in_a, in_b);
        exp_valid = 1'b1;
        exp_zero  = 1'b0;
      end else begin
        q.push_back(in_a);
        if (q.size() == D) begin
          r = q[0];
          for (int i = 1; i < q.size(); i++) r = fn(m_op, r, q[i]);
          exp_data  = r;
          exp_valid = 1'b1;
          exp_zero  = 1'b0;
          q.delete();
        end
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, !rst && !exp_valid);
    chk("busy", busy, exp_valid || (q.size() != 0));
    if (exp_valid) begin
      chk("out_data", out_data, exp_data);
      chk("out_parity", out_parity, ^exp_data);
    end else if (exp_zero) begin
      chk("out_data_rst", out_data, 8'h00);
      chk("out_parity_rst", out_parity, 1'b0);
    end
  endtask

  task automatic half_to_neg();
    @(negedge clk);
    compare();
  endtask

  task automatic half_to_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    half_to_neg();
    half_to_pos();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input logic md);
    in_a = a; in_b = b; op = o; mode = md; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [7:0] exp, input string name, input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      half_to_neg();
      if (out_valid) begin
        found = 1'b1;
        chk(name, out_data, exp);
        chk({name, "_par"}, out_parity, ^exp);
      end
      half_to_pos();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: out_valid not seen within %0d cycles, expected data %0h", name, lim, exp);
    end
  endtask

  logic [7:0] tt      [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
  logic [7:0] xor_in  [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  int         xor_gap [3] = '{0, 3, 0};
  logic [7:0] nand_in [4] = '{8'hFF, 8'h0F, 8'hF0, 8'hFF};
  logic [2:0] nand_op [4] = '{3'd3, 3'd1, 3'd7, 3'd0};
  logic [7:0] or_in   [4] = '{8'h01, 8'h10, 8'h00, 8'h80};
  logic [0:0] w1_exp  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] d1_in   [2] = '{8'hA5, 8'h3C};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; op = 3'd0; mode = 1'b0; out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_in_a = 8'h00; d1_in_b = 8'h00; d1_op = 3'd5; d1_mode = 1'b1; d1_out_ready = 1'b1;
    w1_in_valid = 1'b0; w1_in_a = 1'b0; w1_in_b = 1'b0; w1_op = 3'd0; w1_mode = 1'b0; w1_out_ready = 1'b1;

    // reset state, with rst still high
    half_to_pos();
    half_to_neg();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    half_to_pos();
    rst = 1'b0;
    step();

    // single-shot truth table on F0/CC, one-cycle latency
    for (int o = 0; o < 8; o++) begin
      send(8'hF0, 8'hCC, 3'(o), 1'b0);
      expect_out(tt[o], $sformatf("tt_op%0d", o), 1);
    end

    // reduce XOR with idle gaps; in_b is noise
    for (int i = 0; i < 4; i++) begin
      send(xor_in[i], 8'($urandom()), 3'd2, 1'b1);
      if (i < 3) repeat (xor_gap[i]) step();
    end
    expect_out(8'h0F, "xor_fold", 1);

    // reduce NAND, op changed mid-fold: FF -> F0 -> 0F -> F0
    for (int i = 0; i < 4; i++) send(nand_in[i], 8'h00, nand_op[i], 1'b1);
    expect_out(8'hF0, "nand_fold", 1);

    // backpressure: result held, no beat consumed while in_valid stays high
    out_ready = 1'b0;
    send(8'hAA, 8'h0F, 3'd0, 1'b0);
    in_a = 8'h55; op = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      half_to_neg();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 8'h0A);
      chk("bp_ready", in_ready, 1'b0);
      half_to_pos();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    half_to_neg();
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_busy", busy, 1'b0);
    half_to_pos();

    // reset after 2 of 4 OR beats, then a clean fold
    send(8'hFF, 8'h00, 3'd1, 1'b1);
    send(8'hFF, 8'h00, 3'd1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    half_to_neg();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_par", out_parity, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    half_to_pos();
    for (int i = 0; i < 4; i++) send(or_in[i], 8'hFF, 3'd1, 1'b1);
    expect_out(8'h91, "or_fold", 1);

    // DEPTH=1 reduce passes in_a through after one beat
    for (int i = 0; i < 2; i++) begin
      d1_in_a = d1_in[i]; d1_in_b = 8'($urandom()); d1_in_valid = 1'b1;
      step();
      d1_in_valid = 1'b0;
      half_to_neg();
      chk("d1_valid", d1_out_valid, 1'b1);
      chk("d1_data", d1_out_data, d1_in[i]);
      chk("d1_par", d1_out_parity, ^d1_in[i]);
      chk("d1_busy", d1_busy, 1'b1);
      chk("d1_ready", d1_in_ready, 1'b0);
      half_to_pos();
    end

    // WIDTH=1 single-shot AND then NOR over all input pairs
    for (int k = 0; k < 8; k++) begin
      w1_op = (k < 4) ? 3'd0 : 3'd4;
      w1_in_a = 1'(k >> 1); w1_in_b = 1'(k); w1_in_valid = 1'b1;
      step();
      w1_in_valid = 1'b0;
      half_to_neg();
      chk($sformatf("w1_valid_%0d", k), w1_out_valid, 1'b1);
      chk($sformatf("w1_data_%0d", k), w1_out_data, w1_exp[k]);
      chk($sformatf("w1_par_%0d", k), w1_out_parity, w1_exp[k]);
      chk("w1_busy", w1_busy, 1'b1);
      chk("w1_ready", w1_in_ready, 1'b0);
      half_to_pos();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
